// File: rtl/exu_result_queue.sv
// exu_result_queue
// ----------------
// Sits behind the execute-stage ALU. The ALU registers its result one clock
// after the operands are presented, so this block carries the instruction's
// metadata across that gap. The metadata waits in a single pending slot until
// the ALU stops waiting, then it is paired with alu_res. The combined record
// goes into a small FIFO that feeds the memory/writeback stage through a
// valid/ready handshake. The pending slot also drives a forwarding tap.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flush           synchronous kill of all pending and queued work
//   in_*            instruction issue from EX (valid/ready plus metadata)
//   alu_res         registered ALU result for the pending instruction
//   alu_wait        ALU multi-cycle busy; alu_res is not valid while high
//   out_*           head FIFO record toward MEM/WB (valid/ready plus fields)
//   fwd_valid/rd    the pending result can be forwarded to register fwd_rd
//   fwd_data        forwarded value (same as alu_res)
module exu_result_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [2:0]      in_mem_size,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_wait,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [2:0]      out_mem_size,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_res,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_OCC   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            wen;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_size;
    logic [XLEN-1:0] store_data;
  } meta_t;

  typedef struct packed {
    meta_t           meta;
    logic [XLEN-1:0] res;
  } rec_t;

  logic          pend_valid;
  meta_t         pend;
  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic [CW:0]   occupancy;
  rec_t          head;

  // Handshake decode. Occupancy counts the FIFO plus the pending slot plus the
  // instruction being offered, so a new accept can never lead to a push into a
  // full FIFO later. The ready term only looks at registered state, rst, flush
  // and alu_wait, so out_ready never reaches in_ready combinationally.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, pend_valid} + (CW+1)'(1);
    in_ready  = !rst && !flush && (occupancy <= DEPTH_OCC)
                && (!pend_valid || !alu_wait);
    accept    = in_valid && in_ready;
    push      = pend_valid && !alu_wait;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    full      = (count == DEPTH_COUNT);
  end

  // Pending slot. A resolving push and a new accept can land on the same edge,
  // in which case the slot is simply refilled with the new instruction.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
    end else if (push) begin
      pend_valid <= 1'b0;
    end
  end

  // Pending metadata only needs capturing; pend_valid says whether it matters.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend.pc         <= in_pc;
      pend.rd         <= in_rd;
      pend.wen        <= in_wen;
      pend.mem_read   <= in_mem_read;
      pend.mem_write  <= in_mem_write;
      pend.mem_size   <= in_mem_size;
      pend.store_data <= in_store_data;
    end
  end

  // FIFO storage. Data is not reset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= '{meta: pend, res: alu_res};
    end
  end

  // FIFO pointers and count. Flush behaves like reset for all control state,
  // so a handshake in the flush cycle is discarded. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The ready rule should make this unreachable; catch it in simulation.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full))
        else $error("exu_result_queue: push into full FIFO");
    end
  end

  // Head record, forced to zero while the FIFO is empty.
  always_comb begin
    head           = mem[rd_ptr];
    out_pc         = '0;
    out_rd         = '0;
    out_wen        = 1'b0;
    out_mem_read   = 1'b0;
    out_mem_write  = 1'b0;
    out_mem_size   = '0;
    out_store_data = '0;
    out_res        = '0;
    if (out_valid) begin
      out_pc         = head.meta.pc;
      out_rd         = head.meta.rd;
      out_wen        = head.meta.wen;
      out_mem_read   = head.meta.mem_read;
      out_mem_write  = head.meta.mem_write;
      out_mem_size   = head.meta.mem_size;
      out_store_data = head.meta.store_data;
      out_res        = head.res;
    end
  end

  // Forwarding tap. Writes to x0 are never forwarded even though the record
  // itself keeps rd=0/wen=1 unchanged.
  always_comb begin
    fwd_valid = pend_valid && !alu_wait && pend.wen && (pend.rd != 5'd0);
    fwd_rd    = pend.rd;
    fwd_data  = alu_res;
  end

endmodule

// File: doc/exu_result_queue.md
Name: exu_result_queue

Overview:
- Downstream neighbour of the execute-stage ALU. The ALU's `res` is registered one clock after its operands are presented; this block carries the matching instruction metadata through that latency.
- Holds metadata in a pending slot until the ALU stops waiting (`alu_wait` low), then pairs it with `alu_res`.
- Queues the combined record in a small FIFO toward the memory/writeback stage with a valid/ready handshake.
- Provides a same-cycle forwarding tap from the pending slot.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 64, data/PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all queued/pending work.
- in_valid  in  1  EX issue presents an instruction; operands are on the ALU inputs this same cycle.
- in_ready  out  1  block can accept an instruction.
- in_pc  in  XLEN  instruction PC.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_mem_size  in  3  funct3 of the load/store.
- in_store_data  in  XLEN  rs2 value for stores.
- alu_res  in  XLEN  ALU registered result.
- alu_wait  in  1  ALU multi-cycle busy; `alu_res` is invalid while high.
- out_valid  out  1  head record valid.
- out_ready  in  1  downstream accepts the head record.
- out_pc, out_rd, out_wen, out_mem_read, out_mem_write, out_mem_size, out_store_data  out  (widths as the matching in_ ports)  head record fields.
- out_res  out  XLEN  head ALU result (an address for loads/stores).
- fwd_valid  out  1  pending-slot result forwardable.
- fwd_rd  out  5  pending rd.
- fwd_data  out  XLEN  equals `alu_res`.

Behaviour:
- Reset:
  - pend_valid=0, count=0, read/write pointers=0.
  - Outputs during and after reset: in_ready=0 while rst is high, out_valid=0, fwd_valid=0.
  - All out_* data fields are 0 while count==0.
- Accept: on an edge with in_valid && in_ready && !flush, latch the in_* fields into the pending slot and set pend_valid=1.
- in_ready = !rst && !flush && (count + pend_valid + 1 <= DEPTH) && (!pend_valid || !alu_wait).
  - Registered-state function only; no combinational path from out_ready.
- Pending resolve:
  - While pend_valid && alu_wait: hold, no push.
  - On an edge with pend_valid && !alu_wait: push {pending fields, alu_res} into the FIFO and clear pend_valid, unless a new accept on the same edge refills it.
  - Minimum latency: in_valid at cycle T → record visible at out_* in cycle T+2.
- Multi-cycle op: `alu_wait` may stay high N cycles. The result is taken in the first cycle with pend_valid && !alu_wait.
- FIFO:
  - pop on out_valid && out_ready; out_valid = (count != 0).
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the in_ready rule. A push while full is a design error and is asserted in simulation.
- Ordering: strict program order. Records are never reordered or dropped except by flush/rst.
- Forwarding: fwd_valid = pend_valid && !alu_wait && pend_wen && (pend_rd != 0); fwd_rd = pend_rd. Purely combinational from state plus `alu_wait`.
- Flush:
  - On an edge with flush=1: pend_valid=0, count=0, pointers=0.
  - A concurrent in_valid is not accepted.
  - A concurrent out handshake is treated as not having occurred. Downstream must also ignore out_valid in a flush cycle.
- rst has priority over flush. Both abort any in-progress ALU wait tracking immediately (reset mid-operation leaves no residue).
- rd=0 with wen=1 passes through unchanged; only forwarding suppresses it.

Test Plan:
- Single op: reset 2 cycles; in_valid for 1 cycle with pc=0x80000000, rd=5, wen=1; alu_res=0x2A on the next cycle, alu_wait=0 → cycle T+1 fwd_valid=1, fwd_rd=5, fwd_data=0x2A; cycle T+2 out_valid=1, out_res=0x2A, out_pc=0x80000000; with out_ready=1, out_valid=0 at T+3.
- Back-to-back stream: 8 instructions, pc 0x0,0x4,…,0x1C, alu_res=pc+1, out_ready=1 always → in_ready stays 1; outputs arrive in order one per cycle, out_res=0x1,0x5,…,0x1D.
- Multi-cycle stall: issue a mul, alu_wait=1 for cycles T+1..T+4, alu_res=0x30 at T+5 with alu_wait=0 → in_ready=0 during T+1..T+4, fwd_valid=0; record out at T+6 with out_res=0x30.
- Backpressure/full: out_ready=0; issue 6 instructions → in_ready falls after count+pend reaches DEPTH (4 accepted); raise out_ready → exactly 4 records drain in order, no loss or duplication; wrap pointers with 10 more.
- Flush: with 3 queued, 1 pending, and in_valid=1 plus out_ready=1 in the same cycle, assert flush → next cycle out_valid=0, fwd_valid=0, count 0; the next issued instruction emerges 2 cycles after its acceptance.
- rd=0: in_rd=0, wen=1 → fwd_valid=0; out_rd=0, out_wen=1 delivered unchanged.
